// File: rtl/etroc_frame_aligner.sv
// ETROC2 readout word aligner and link monitor.
// Searches a free-running deserialized word stream for the frame header,
// locks onto its bit offset with hysteresis, emits realigned frames and
// keeps saturating link-health counters.
module etroc_frame_aligner #(
    parameter int                  W            = 40,
    parameter int                  HDRWIDTH     = 16,
    parameter logic [HDRWIDTH-1:0] HEADER       = 16'h3C5C,
    parameter int                  LOCK_COUNT   = 4,
    parameter int                  UNLOCK_COUNT = 2,
    parameter int                  MAX_GAP      = 16,
    parameter int                  CNTWIDTH     = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [W-1:0]         dataIn,
    input  logic                 dataValid,
    input  logic                 relock,
    output logic [W-1:0]         alignedData,
    output logic                 alignedValid,
    output logic                 aligned,
    output logic [$clog2(W)-1:0] bitOffset,
    output logic                 headerFlag,
    output logic [CNTWIDTH-1:0]  gapErrorCount,
    output logic [CNTWIDTH-1:0]  relockCount
);

    localparam int OFFW  = $clog2(W);
    localparam int GOODW = $clog2(LOCK_COUNT + 1);
    localparam int GAPW  = $clog2(MAX_GAP + 1);
    localparam int MISSW = $clog2(UNLOCK_COUNT + 1);

    // Counter values that, when hit again, complete the count.
    localparam logic [GOODW-1:0] LOCK_LAST = GOODW'(LOCK_COUNT - 1);
    localparam logic [GAPW-1:0]  GAP_LAST  = GAPW'(MAX_GAP - 1);
    localparam logic [MISSW-1:0] MISS_LAST = MISSW'(UNLOCK_COUNT - 1);

    typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} stateType;

    stateType         state, nextState;
    logic [OFFW-1:0]  nextOffset, firstOffset;
    logic [GOODW-1:0] goodCnt, nextGood;
    logic [GAPW-1:0]  gapCnt, nextGap;
    logic [MISSW-1:0] missCnt, nextMiss;
    logic             bumpGapErr, bumpRelock;

    logic [W-1:0]     prevWord;
    logic [W-1:0]     matchVec;
    logic [W-1:0]     candidate;
    logic             anyMatch, curMatch;

    // The largest offset W-1 reaches down to bit 1 of the new word, so the
    // window never needs the last received bit.
    logic [2*W-1:1]   win;
    assign win = {prevWord, dataIn[W-1:1]};

    // Header match at every offset, lowest matching offset, and the frame at the held offset.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        matchVec    = '0;
        candidate   = '0;
        firstOffset = '0;
        for (int k = 0; k < W; k++) begin
            matchVec[k] = (win[2*W-1-k -: HDRWIDTH] == HEADER);
            if (bitOffset == OFFW'(k)) candidate = win[2*W-1-k -: W];
        end
        for (int k = W - 1; k >= 0; k--) begin
            if (matchVec[k]) firstOffset = OFFW'(k);
        end
        anyMatch = |matchVec;
        curMatch = (candidate[W-1 -: HDRWIDTH] == HEADER);
    end

    // Next-state and counter-update logic; relock overrides every other transition.
    always_comb begin
        nextState  = state;
        nextOffset = bitOffset;
        nextGood   = goodCnt;
        nextGap    = gapCnt;
        nextMiss   = missCnt;
        bumpGapErr = 1'b0;
        bumpRelock = 1'b0;
        if (relock) begin
            nextState  = SEARCH;
            nextGood   = '0;
            nextGap    = '0;
            nextMiss   = '0;
            bumpRelock = (state == LOCKED);
        end else if (dataValid) begin
            case (state)
                SEARCH: begin
                    if (anyMatch) begin
                        nextOffset = firstOffset;
                        nextGood   = GOODW'(1);
                        nextGap    = '0;
                        nextMiss   = '0;
                        nextState  = (LOCK_COUNT == 1) ? LOCKED : CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (curMatch) begin
                        nextGood = goodCnt + 1'b1;
                        nextGap  = '0;
                        if (goodCnt == LOCK_LAST) begin
                            nextState = LOCKED;
                            nextMiss  = '0;
                        end
                    end else if (gapCnt == GAP_LAST) begin
                        nextState  = SEARCH;
                        nextGap    = '0;
                        nextGood   = '0;
                        bumpGapErr = 1'b1;
                    end else begin
                        nextGap = gapCnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (curMatch) begin
                        nextGap  = '0;
                        nextMiss = '0;
                    end else if (gapCnt == GAP_LAST) begin
                        nextGap    = '0;
                        bumpGapErr = 1'b1;
                        if (missCnt == MISS_LAST) begin
                            nextState  = SEARCH;
                            nextMiss   = '0;
                            bumpRelock = 1'b1;
                        end else begin
                            nextMiss = missCnt + 1'b1;
                        end
                    end else begin
                        nextGap = gapCnt + 1'b1;
                    end
                end
                default: nextState = SEARCH;
            endcase
        end
    end

    // State register, held offset and hysteresis counters.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (reset) begin
            state     <= SEARCH;
            bitOffset <= '0;
            goodCnt   <= '0;
            gapCnt    <= '0;
            missCnt   <= '0;
        end else begin
            state     <= nextState;
            bitOffset <= nextOffset;
            goodCnt   <= nextGood;
            gapCnt    <= nextGap;
            missCnt   <= nextMiss;
        end
    end

    // Word history and registered frame outputs; idle cycles hold the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prevWord     <= '0;
            alignedData  <= '0;
            headerFlag   <= 1'b0;
            alignedValid <= 1'b0;
            aligned      <= 1'b0;
        end else begin
            alignedValid <= dataValid && (state == LOCKED);
            aligned      <= (nextState == LOCKED);
            if (dataValid) begin
                prevWord    <= dataIn;
                alignedData <= candidate;
                headerFlag  <= curMatch;
            end
        end
    end

    // Saturating link-health counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gapErrorCount <= '0;
            relockCount   <= '0;
        end else begin
            if (bumpGapErr && (gapErrorCount != '1)) gapErrorCount <= gapErrorCount + 1'b1;
            if (bumpRelock && (relockCount != '1))   relockCount   <= relockCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_etroc_frame_aligner.sv
// Self-checking bench for etroc_frame_aligner: a stream-level reference model
// checked every cycle, plus directed checks on lock, unlock, relock, reset
// and counter saturation (second instance with 4-bit counters).
module tb_etroc_frame_aligner;

    localparam int               W            = 40;
    localparam int               HDRWIDTH     = 16;
    localparam logic [15:0]      HEADER       = 16'h3C5C;
    localparam int               LOCK_COUNT   = 4;
    localparam int               UNLOCK_COUNT = 2;
    localparam int               MAX_GAP      = 16;
    localparam int               CW           = 20;
    localparam int               CWS          = 4;
    localparam int               PW           = W - HDRWIDTH;
    localparam int               OFFW         = $clog2(W);

    // Model modes
    localparam int HUNT = 0, VERIFY = 1, TRACK = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  dataIn = '0;
    logic          dataValid = 1'b0;
    logic          relock = 1'b0;

    logic [W-1:0]    alignedData, sAlignedData;
    logic            alignedValid, sAlignedValid;
    logic            aligned, sAligned;
    logic [OFFW-1:0] bitOffset, sBitOffset;
    logic            headerFlag, sHeaderFlag;
    logic [CW-1:0]   gapErrorCount, relockCount;
    logic [CWS-1:0]  sGapErrorCount, sRelockCount;

    etroc_frame_aligner #(
        .W(W), .HDRWIDTH(HDRWIDTH), .HEADER(HEADER), .LOCK_COUNT(LOCK_COUNT),
        .UNLOCK_COUNT(UNLOCK_COUNT), .MAX_GAP(MAX_GAP), .CNTWIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .dataIn(dataIn), .dataValid(dataValid), .relock(relock),
        .alignedData(alignedData), .alignedValid(alignedValid), .aligned(aligned),
        .bitOffset(bitOffset), .headerFlag(headerFlag),
        .gapErrorCount(gapErrorCount), .relockCount(relockCount)
    );

    etroc_frame_aligner #(
        .W(W), .HDRWIDTH(HDRWIDTH), .HEADER(HEADER), .LOCK_COUNT(LOCK_COUNT),
        .UNLOCK_COUNT(UNLOCK_COUNT), .MAX_GAP(MAX_GAP), .CNTWIDTH(CWS)
    ) dutSat (
        .clk(clk), .reset(reset), .dataIn(dataIn), .dataValid(dataValid), .relock(relock),
        .alignedData(sAlignedData), .alignedValid(sAlignedValid), .aligned(sAligned),
        .bitOffset(sBitOffset), .headerFlag(sHeaderFlag),
        .gapErrorCount(sGapErrorCount), .relockCount(sRelockCount)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Bit n of the received stream, n = 0 being the oldest bit of the window.
    function automatic bit streamBit(input logic [W-1:0] p, input logic [W-1:0] d, input int n);
        if (n < W) return p[W-1-n];
        return d[2*W-1-n];
    endfunction

    function automatic logic [W-1:0] candAt(input logic [W-1:0] p, input logic [W-1:0] d, input int k);
        logic [W-1:0] c;
        for (int i = 0; i < W; i++) c[W-1-i] = streamBit(p, d, k + i);
        return c;
    endfunction

    function automatic int firstHit(input logic [W-1:0] p, input logic [W-1:0] d);
        logic [W-1:0] c;
        for (int k = 0; k < W; k++) begin
            c = candAt(p, d, k);
            if (c[W-1 -: HDRWIDTH] == HEADER) return k;
        end
        return -1;
    endfunction

    function automatic longint satv(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    logic [W-1:0] mPrev = '0;
    int           mMode = HUNT;
    int           mOff = 0, mHits = 0, mQuiet = 0, mStrikes = 0;
    longint       mGapErrs = 0, mRelocks = 0;
    logic [W-1:0] eData = '0;
    bit           eValid = 1'b0, eAligned = 1'b0, eHdr = 1'b0;

    always @(posedge clk or posedge reset) begin
        logic [W-1:0] c;
        bit           hit;
        int           f;
        if (reset) begin
            mPrev = '0; mMode = HUNT; mOff = 0; mHits = 0; mQuiet = 0; mStrikes = 0;
            mGapErrs = 0; mRelocks = 0;
            eData = '0; eValid = 1'b0; eAligned = 1'b0; eHdr = 1'b0;
        end else begin
            c   = candAt(mPrev, dataIn, mOff);
            hit = (c[W-1 -: HDRWIDTH] == HEADER);
            eValid = dataValid && (mMode == TRACK);
            if (dataValid) begin
                eData = c;
                eHdr  = hit;
            end
            if (relock) begin
                if (mMode == TRACK) mRelocks++;
                mMode = HUNT; mHits = 0; mQuiet = 0; mStrikes = 0;
            end else if (dataValid) begin
                if (mMode == HUNT) begin
                    f = firstHit(mPrev, dataIn);
                    if (f >= 0) begin
                        mOff = f; mHits = 1; mQuiet = 0; mStrikes = 0;
                        mMode = (mHits >= LOCK_COUNT) ? TRACK : VERIFY;
                    end
                end else if (hit) begin
                    mQuiet = 0;
                    if (mMode == VERIFY) begin
                        mHits++;
                        if (mHits >= LOCK_COUNT) begin
                            mMode = TRACK;
                            mStrikes = 0;
                        end
                    end else begin
                        mStrikes = 0;
                    end
                end else begin
                    mQuiet++;
                    if (mQuiet >= MAX_GAP) begin
                        mQuiet = 0;
                        mGapErrs++;
                        if (mMode == VERIFY) begin
                            mMode = HUNT;
                        end else begin
                            mStrikes++;
                            if (mStrikes >= UNLOCK_COUNT) begin
                                mMode = HUNT;
                                mStrikes = 0;
                                mRelocks++;
                            end
                        end
                    end
                end
            end
            if (dataValid) mPrev = dataIn;
            eAligned = (mMode == TRACK);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("cmp.alignedData",   alignedData,    eData);
            check("cmp.alignedValid",  alignedValid,   eValid);
            check("cmp.aligned",       aligned,        eAligned);
            check("cmp.headerFlag",    headerFlag,     eHdr);
            check("cmp.bitOffset",     bitOffset,      mOff);
            check("cmp.gapErrorCount", gapErrorCount,  satv(mGapErrs, CW));
            check("cmp.relockCount",   relockCount,    satv(mRelocks, CW));
            check("cmp.sat.aligned",   sAligned,       eAligned);
            check("cmp.sat.gapErrors", sGapErrorCount, satv(mGapErrs, CWS));
            check("cmp.sat.relocks",   sRelockCount,   satv(mRelocks, CWS));
        end
    end

    // ---------------- stimulus ----------------
    logic [W-1:0] prevFrame = '0;
    int           fIdx = 0;
    int           curOff = 0;

    task automatic drive(input logic [W-1:0] d, input logic v, input logic r);
        @(negedge clk);
        #1;
        dataIn = d; dataValid = v; relock = r;
        @(posedge clk);
        #2;
    endtask

    task automatic startStream(input int off);
        curOff = off; prevFrame = '0; fIdx = 0;
    endtask

    // Sends the next frame of a stream delayed by curOff bits.
    task automatic sendFrame(input bit isHdr, input bit doRelock);
        logic [W-1:0]   frame;
        logic [2*W-1:0] sh;
        frame = isHdr ? {HEADER, PW'(fIdx)} : {{HDRWIDTH{1'b0}}, PW'(fIdx)};
        sh = {prevFrame, frame} >> curOff;
        drive(sh[W-1:0], 1'b1, doRelock);
        prevFrame = frame;
        fIdx++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive({HEADER, HEADER, 8'hA5}, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] twoHdr;

        // Reset state
        @(posedge clk);
        #2;
        check("rst.aligned",      aligned,       1'b0);
        check("rst.alignedValid", alignedValid,  1'b0);
        check("rst.alignedData",  alignedData,   40'h0);
        check("rst.bitOffset",    bitOffset,     6'd0);
        check("rst.headerFlag",   headerFlag,    1'b0);
        check("rst.gapErrors",    gapErrorCount, 20'd0);
        check("rst.relocks",      relockCount,   20'd0);
        started = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;

        // Lock at offset 13, header every 4th frame
        startStream(13);
        for (int i = 0; i <= 17; i++) begin
            sendFrame(i % 4 == 0, 1'b0);
            if (i == 12) check("lock.notYet", aligned, 1'b0);
            if (i == 13) begin
                check("lock.aligned",   aligned,   1'b1);
                check("lock.bitOffset", bitOffset, 6'd13);
                check("model.offset",   mOff,      13);
            end
            if (i >= 14) begin
                check("lock.alignedValid", alignedValid, 1'b1);
                check("lock.headerPulse",  headerFlag,   i == 17);
            end
        end
        check("lock.hdrField",  alignedData[39:24], 16'h3C5C);
        check("lock.frameData", alignedData,        40'h3C5C000010);

        // Headers removed: two gap timeouts drop the lock
        for (int m = 1; m <= 32; m++) begin
            sendFrame(1'b0, 1'b0);
            if (m == 15) check("gap.before1", gapErrorCount, 20'd0);
            if (m == 16) begin
                check("gap.first",     gapErrorCount, 20'd1);
                check("gap.stillLock", aligned,       1'b1);
            end
            if (m == 31) check("gap.lockAt31", aligned, 1'b1);
            if (m == 32) begin
                check("gap.second",   gapErrorCount, 20'd2);
                check("gap.unlocked", aligned,       1'b0);
                check("gap.relocks",  relockCount,   20'd1);
                check("model.gapErr", mGapErrs,      2);
            end
        end

        // Two headers in one window (offsets 5 and 22): lowest wins
        twoHdr = (40'(HEADER) << 19) | (40'(HEADER) << 2);
        drive(twoHdr, 1'b1, 1'b0);
        drive(40'h0, 1'b1, 1'b0);
        check("dual.bitOffset", bitOffset, 6'd5);
        check("dual.notLocked", aligned,   1'b0);
        // relock while confirming does not count as a relock
        drive(40'h0, 1'b1, 1'b1);
        check("dual.relockCnt", relockCount, 20'd1);

        // Gapped valid (1 of 3) during confirm, offset 27, header every 8th frame
        startStream(27);
        for (int i = 0; i <= 25; i++) begin
            sendFrame(i % 8 == 0, 1'b0);
            if (i == 24) check("gapped.notYet", aligned, 1'b0);
            if (i == 25) begin
                check("gapped.aligned",   aligned,   1'b1);
                check("gapped.bitOffset", bitOffset, 6'd27);
            end
            idle(2);
        end
        check("gapped.idleValid", alignedValid,  1'b0);
        check("gapped.noGapErr",  gapErrorCount, 20'd2);

        // Relock while locked, coincident with a header; then relock normally
        for (int i = 26; i <= 67; i++) begin
            sendFrame(i % 8 == 0, i == 33);
            if (i == 33) begin
                check("relock.aligned", aligned,       1'b0);
                check("relock.count",   relockCount,   20'd2);
                check("relock.gapErr",  gapErrorCount, 20'd2);
            end
            if (i == 64) check("relock.notYet", aligned, 1'b0);
            if (i == 65) begin
                check("relock.relocked",  aligned,   1'b1);
                check("relock.bitOffset", bitOffset, 6'd27);
            end
        end

        // Asynchronous reset mid-frame
        check("areset.validBefore", alignedValid, 1'b1);
        #1 reset = 1'b1;
        dataValid = 1'b0;
        #1;
        check("areset.aligned",      aligned,       1'b0);
        check("areset.alignedValid", alignedValid,  1'b0);
        check("areset.alignedData",  alignedData,   40'h0);
        check("areset.headerFlag",   headerFlag,    1'b0);
        check("areset.bitOffset",    bitOffset,     6'd0);
        check("areset.relocks",      relockCount,   20'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;

        // Continuous confirm timeouts: 4-bit counter saturates at 15
        startStream(13);
        for (int r = 0; r < 20; r++) begin
            sendFrame(1'b1, 1'b0);
            repeat (17) sendFrame(1'b0, 1'b0);
            if (r == 14) check("sat.reach15", sGapErrorCount, 4'd15);
            if (r == 15) begin
                check("sat.noWrap", sGapErrorCount, 4'd15);
                check("sat.wide16", gapErrorCount,  20'd16);
            end
        end
        check("sat.final",     sGapErrorCount, 4'd15);
        check("sat.wideFinal", gapErrorCount,  20'd20);
        check("sat.relocks",   relockCount,    20'd0);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
